disp_scan: RTL and testbench
============================

// Module: disp_scan
// PURPOSE
//  Downstream of the calculator core: captures the serial digit stream (data/pos/status) into
//  an 8-digit frame buffer and time-multiplexes it onto an 8-digit common-anode 7-segment display.
//  Commits only complete frames, so a partially streamed number is never shown.
//  Blanks leading zeros and overrides the display with "Erro" on error status.
// PARAMETERS
//  N_DIGITS     8      digits in buffer/display; pos range 1..N_DIGITS
//  REFRESH_DIV  50000  clock cycles each digit is lit during scan (>=2)
// PORTS
//  clock   in   1  system clock; everything is sampled on its rising edge
//  reset   in   1  asynchronous, active-high reset
//  status  in   2  core status: 00 erro, 01 ocupado, 10 pronto, 11 imprimindo
//  data    in   4  BCD digit from core
//  pos     in   4  core write position; 0 = idle
//  an      out  8  anode enables, active-low, one-hot while scanning
//  seg     out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp      out  1  decimal point, active-low; held 1 (off)
// BEHAVIOUR
//  Reset: an=8'hFF, seg=7'h7F, dp=1; staging/display buffers=0; scan idx=0; div cnt=0;
//   exp_pos=1; frame_ok=0. Display shows "0" on digit 0 after the first slot.
//  Write: status==11 && 1<=pos<=N_DIGITS is a write; digit index = pos-1 (index 0 = units).
//   data and pos arrive in the same cycle; each write is sampled exactly once.
//  Frame FSM states IDLE, FILL:
//   IDLE: write with pos==1 -> staging[0]<=data, exp_pos<=2, go FILL. Other writes ignored.
//   FILL: write with pos==exp_pos -> staging[pos-1]<=data, exp_pos++.
//     pos==N_DIGITS write accepted -> next cycle display<=staging, go IDLE (commit latency 1).
//     write with pos==1 -> restart frame (staging[0]<=data, exp_pos<=2).
//     any other write pos, or status==00 -> abort, go IDLE, display unchanged.
//     cycles with no write (status!=11 or pos==0 or pos>N_DIGITS) hold FILL.
//  Scan: div cnt counts 0..REFRESH_DIV-1; on wrap idx<=(idx==N_DIGITS-1)?0:idx+1.
//   an/seg registered: an[idx]=0 and seg=pattern(idx) one cycle after idx changes.
//  Blanking: digit k blank if k>0 and display[k..N_DIGITS-1] all zero; digit 0 never blank.
//   Codes 10..15 in buffer decode to blank.
//  Error: while status==00, digits 3..0 show E,r,r,o, digits 7..4 blank; buffers untouched;
//   normal display resumes the slot after status leaves 00.
//  Simultaneous: commit and scan advance in the same cycle -> new slot uses committed buffer.
//  Reset mid-frame: staging discarded, display buffer cleared, scan restarts at idx 0.
// STRUCTURE
//  calc_pkg: STATUS_ERRO/OCUPADO/PRONTO/IMPRIMINDO constants; SEG_BLANK, SEG_E, SEG_R,
//   SEG_O patterns; frame-state enum (IDLE, FILL).
//  Sub-module seg7_decoder (combinational, 4-bit code -> 7-bit active-low pattern, 10..15 blank).
//  Top: frame FSM + staging/display buffers, refresh divider, scan mux, output registers.
// TESTING (bench uses REFRESH_DIV=4)
//  Reset -> an=FF, seg=7F, dp=1; after first slot an=FE, seg=7'b1000000 ("0"); digits 7..1 stay blank.
//  Stream 4,3,2,1,0,0,0,0 at pos 1..8, status=11 -> after commit units show 4, tens 3,
//   hundreds 2, thousands 1; digits 7..4 blank.
//  Partial stream pos 1..5 then status=10 and pos=0 -> display unchanged; staging not committed.
//  Stream with pos 1,2,4 -> abort; the next clean 1..8 stream commits normally.
//  status=00 -> digits 3..0 show E,r,r,o, 7..4 blank; status=10 -> prior number returns.
//  Assert reset at pos=5 of a stream -> all buffers 0, an=FF; the next full stream commits normally.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared status codes, glyph patterns and frame states for the display path
package calc_pkg;

  localparam logic [1:0] STATUS_ERRO       = 2'b00;
  localparam logic [1:0] STATUS_OCUPADO    = 2'b01;
  localparam logic [1:0] STATUS_PRONTO     = 2'b10;
  localparam logic [1:0] STATUS_IMPRIMINDO = 2'b11;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } frame_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD code to active-low 7-segment pattern, non-decimal codes blank
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Pure lookup; codes 10..15 never reach the glass as glyphs
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - frame capture of the core digit stream and multiplexed 7-segment scan
module disp_scan
  import calc_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          status,
  input  logic [3:0]          data,
  input  logic [3:0]          pos,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [3:0]       LAST_POS = 4'(N_DIGITS);
  // exp_pos one past the last digit marks a complete frame awaiting commit
  localparam logic [3:0]       EXP_DONE = 4'(N_DIGITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);

  frame_state_t     state;
  logic [3:0]       exp_pos;
  logic [3:0]       staging [N_DIGITS];
  logic [3:0]       display [N_DIGITS];
  logic [CNT_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;

  logic                is_write;
  logic                commit;
  logic                wrap;
  logic [3:0]          disp_next [N_DIGITS];
  logic [N_DIGITS-1:0] blank;
  logic                hi_zero;
  logic [3:0]          cur_code;
  logic [6:0]          dec_pat;
  logic [6:0]          err_pat;
  logic [6:0]          next_seg;

  assign is_write = (status == STATUS_IMPRIMINDO) && (pos != 4'd0) && (pos <= LAST_POS);
  assign commit   = (state == FILL) && (exp_pos == EXP_DONE);
  assign wrap     = (div_cnt == CNT_MAX);
  assign dp       = 1'b1;

  // Frame FSM: stage digits in strict 1..N order, publish the whole frame one cycle after the last
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      exp_pos <= 4'd1;
      for (int i = 0; i < N_DIGITS; i++) begin
        staging[i] <= 4'd0;
        display[i] <= 4'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (is_write && pos == 4'd1) begin
            staging[0] <= data;
            exp_pos    <= 4'd2;
            state      <= FILL;
          end
        end
        FILL: begin
          if (commit) begin
            display <= staging;
            exp_pos <= 4'd1;
            state   <= IDLE;
          end else if (status == STATUS_ERRO) begin
            exp_pos <= 4'd1;
            state   <= IDLE;
          end else if (is_write) begin
            if (pos == 4'd1) begin
              staging[0] <= data;
              exp_pos    <= 4'd2;
            end else if (pos == exp_pos) begin
              staging[IDX_W'(pos - 4'd1)] <= data;
              exp_pos                     <= exp_pos + 4'd1;
            end else begin
              exp_pos <= 4'd1;
              state   <= IDLE;
            end
          end
        end
        default: begin
          exp_pos <= 4'd1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Refresh divider: each digit owns REFRESH_DIV cycles, then the scan moves to the next one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (wrap) begin
      div_cnt <= '0;
      idx     <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Buffer seen by the next slot; bypasses a commit landing on the same edge
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      disp_next[i] = commit ? staging[i] : display[i];
    end
  end

  // Leading-zero blanking: a digit is dark when it and everything above it are zero
  always_comb begin
    hi_zero = 1'b1;
    blank   = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      hi_zero  = hi_zero & (disp_next[k] == 4'd0);
      blank[k] = (k != 0) & hi_zero;
    end
  end

  assign cur_code = disp_next[idx];

  seg7_decoder u_dec (
    .code    (cur_code),
    .pattern (dec_pat)
  );

  // Error overlay spells "Erro" across the low four digits
  always_comb begin
    err_pat = SEG_BLANK;
    if (idx == IDX_W'(0))
      err_pat = SEG_O;
    else if (idx == IDX_W'(1) || idx == IDX_W'(2))
      err_pat = SEG_R;
    else if (idx == IDX_W'(3))
      err_pat = SEG_E;
    next_seg = (status == STATUS_ERRO) ? err_pat : (blank[idx] ? SEG_BLANK : dec_pat);
  end

  // Output registers load once per slot so the lit digit never glitches mid-slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (wrap) begin
      an  <= ~(N_DIGITS'(1) << idx);
      seg <= next_seg;
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - randomized and directed self-checking bench for disp_scan
module tb_disp_scan;

  localparam int N   = 8;
  localparam int DIV = 4;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] status = 2'b10;
  logic [3:0] data   = 4'd0;
  logic [3:0] pos    = 4'd0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  disp_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clock  (clock),
    .reset  (reset),
    .status (status),
    .data   (data),
    .pos    (pos),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference glyphs, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G9 = 7'b0010000;
  localparam logic [6:0] GE = 7'b0000110, GR = 7'b0101111, GO = 7'b0100011, GB = 7'b1111111;

  function automatic logic [6:0] glyph(input int code);
    case (code)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Model state: shown number, partially received frame as a queue, pending commit
  int         m_disp [N];
  int         q[$];
  bit         pending;
  int         n_edge;
  logic [7:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [6:0] expect_seg(input int k, input logic [1:0] st);
    bit allz;
    if (st == 2'b00) begin
      if (k == 0) return GO;
      if (k == 1 || k == 2) return GR;
      if (k == 3) return GE;
      return GB;
    end
    allz = 1'b1;
    for (int j = k; j < N; j++) if (m_disp[j] != 0) allz = 1'b0;
    if (k > 0 && allz) return GB;
    return glyph(m_disp[k]);
  endfunction

  always @(posedge clock) begin : model_b
    bit w;
    int k;
    if (reset) begin
      for (int i = 0; i < N; i++) m_disp[i] = 0;
      q.delete();
      pending = 1'b0;
      n_edge  = 0;
      m_an    = 8'hFF;
      m_seg   = 7'h7F;
    end else begin
      n_edge++;
      if (pending) begin
        for (int i = 0; i < N; i++) m_disp[i] = q[i];
        q.delete();
        pending = 1'b0;
      end else begin
        w = (status == 2'b11) && (pos >= 1) && (pos <= N);
        if (q.size() > 0) begin
          if (status == 2'b00) q.delete();
          else if (w) begin
            if (pos == 1) begin
              q.delete();
              q.push_back(int'(data));
            end else if (int'(pos) == q.size() + 1) begin
              q.push_back(int'(data));
              if (q.size() == N) pending = 1'b1;
            end else begin
              q.delete();
            end
          end
        end else if (w && pos == 1) begin
          q.push_back(int'(data));
        end
      end
      if (n_edge % DIV == 0) begin
        k     = (n_edge / DIV - 1) % N;
        m_an  = ~(8'b1 << k);
        m_seg = expect_seg(k, status);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("scan_an", an, m_an);
      check("scan_seg", seg, m_seg);
      check("scan_dp", dp, 1'b1);
    end
  end

  task automatic drive(input logic [1:0] s, input logic [3:0] d, input logic [3:0] p);
    @(negedge clock);
    #2;
    status = s;
    data   = d;
    pos    = p;
  endtask

  task automatic stream_frame(input logic [31:0] digits);
    for (int i = 0; i < N; i++) drive(2'b11, digits[4*i +: 4], 4'(i + 1));
    drive(2'b10, 4'd0, 4'd0);
  endtask

  task automatic wait_digit(input int k, input logic [6:0] exp, input string name);
    repeat (DIV + 1) @(negedge clock);
    for (int c = 0; c < 4 * N * DIV; c++) begin
      if (an == ~(8'b1 << k)) begin
        check(name, seg, exp);
        return;
      end
      @(negedge clock);
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: digit %0d never lit, an=%h", name, k, an);
  endtask

  initial begin : stim
    int next_p;
    int r;
    repeat (3) @(negedge clock);
    check("reset_an", an, 8'hFF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    @(negedge clock);
    #2 reset = 1'b0;

    wait_digit(0, G0, "boot_d0_zero");
    wait_digit(1, GB, "boot_d1_blank");

    stream_frame(32'h0000_1234);
    wait_digit(0, G4, "frame1_d0");
    wait_digit(1, G3, "frame1_d1");
    wait_digit(2, G2, "frame1_d2");
    wait_digit(3, G1, "frame1_d3");
    wait_digit(4, GB, "frame1_d4_blank");
    wait_digit(7, GB, "frame1_d7_blank");

    for (int i = 1; i <= 5; i++) drive(2'b11, 4'd9, 4'(i));
    drive(2'b10, 4'd0, 4'd0);
    wait_digit(0, G4, "partial_d0_kept");
    wait_digit(4, GB, "partial_d4_kept");

    drive(2'b11, 4'd7, 4'd1);
    drive(2'b11, 4'd7, 4'd2);
    drive(2'b11, 4'd7, 4'd4);
    drive(2'b10, 4'd0, 4'd0);
    wait_digit(0, G4, "abort_d0_kept");
    stream_frame(32'h1009_8765);
    wait_digit(0, G5, "frame2_d0");
    wait_digit(4, G9, "frame2_d4");
    wait_digit(5, G0, "frame2_d5_inner_zero");
    wait_digit(7, G1, "frame2_d7");

    drive(2'b00, 4'd0, 4'd0);
    wait_digit(3, GE, "err_d3_E");
    wait_digit(2, GR, "err_d2_r");
    wait_digit(0, GO, "err_d0_o");
    wait_digit(6, GB, "err_d6_blank");
    drive(2'b10, 4'd0, 4'd0);
    wait_digit(7, G1, "resume_d7");
    wait_digit(0, G5, "resume_d0");

    for (int i = 1; i <= 4; i++) drive(2'b11, 4'd3, 4'(i));
    drive(2'b11, 4'd3, 4'd5);
    reset = 1'b1;
    #1;
    check("midreset_an", an, 8'hFF);
    check("midreset_seg", seg, 7'h7F);
    repeat (2) @(negedge clock);
    #2;
    reset  = 1'b0;
    status = 2'b10;
    pos    = 4'd0;
    wait_digit(0, G0, "postreset_d0_zero");
    wait_digit(3, GB, "postreset_d3_blank");
    stream_frame(32'h0000_0002);
    wait_digit(0, G2, "frame3_d0");
    wait_digit(1, GB, "frame3_d1_blank");

    next_p = 1;
    for (int c = 0; c < 2000; c++) begin
      logic [1:0] s;
      logic [3:0] p;
      logic [3:0] d;
      r = $urandom_range(0, 99);
      s = (r < 85) ? 2'b11 : 2'($urandom_range(0, 2));
      p = ($urandom_range(0, 5) != 0) ? 4'(next_p) : 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if (s == 2'b11 && int'(p) == next_p) next_p = (next_p == N) ? 1 : next_p + 1;
      drive(s, d, p);
    end
    drive(2'b10, 4'd0, 4'd0);
    repeat (2 * N * DIV) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
